systolic_ctrl: RTL and testbench

Sequencer for the DIM x DIM output-stationary systolic_array.
- Accepts matrices A and B as row-wide beats over a valid/ready load port.
- Clears the array accumulators, then drives the skewed left and top operand wavefronts.
- Waits out the propagation latency, then snapshots the packed result into a holding register and presents it on a valid/ready result port.
- Sits between the host/DMA side and one systolic_array instance.

---
 rtl/systolic_ctrl.sv | 171 +++++++++++++++++
 tb/tb_systolic_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a DIM x DIM output-stationary systolic array.
// Loads A and B as row beats, clears the array, feeds skewed operand
// wavefronts, waits out propagation, then holds the packed result for a
// valid/ready consumer.
// Optional feature macro: SYSTOLIC_CTRL_ACCUM_EN adds input acc_keep; when it
// is sampled high on the last load beat, the CLEAR cycle leaves the array
// accumulators intact so new products add onto the previous tile.
//
// state | meaning
// LOAD  | accept 2*DIM row beats: A rows 0..DIM-1, then B rows 0..DIM-1
// CLEAR | single cycle, array accumulators cleared, operands zero
// FEED  | skewed wavefronts, t = 0..3*DIM-2 (last t is a settle cycle)
// OUT   | captured result held on res_data until res_ready
module systolic_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIM   = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DIM*WIDTH-1:0]       ld_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  input  logic                       acc_keep,
`endif
  output logic                       arr_reset,
  output logic [DIM*WIDTH-1:0]       arr_inp_left,
  output logic [DIM*WIDTH-1:0]       arr_inp_top,
  input  logic [2*DIM*DIM*WIDTH-1:0] arr_result,
  output logic [2*DIM*DIM*WIDTH-1:0] res_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int LW = DIM*WIDTH;
  localparam int RW = 2*DIM*DIM*WIDTH;
  localparam int BW = $clog2(2*DIM);
  localparam int TW = $clog2(3*DIM-1);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_FEED  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [BW-1:0] LAST_BEAT = BW'(2*DIM-1);
  localparam logic [TW-1:0] LAST_T    = TW'(3*DIM-2);

  logic [1:0]       r_state;
  logic [BW-1:0]    r_beat;
  logic [TW-1:0]    r_t;
  logic [RW-1:0]    r_res_data;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_a [DIM][DIM];
  logic [WIDTH-1:0] r_b [DIM][DIM];
  logic             r_keep;

  logic             w_xfer;
  logic             w_last_beat;
  logic             w_t_last;
  logic             w_clear_arr;
  logic [LW-1:0]    w_left;
  logic [LW-1:0]    w_top;

  // Handshake and terminal-count decodes
  always_comb begin
    ld_ready    = !reset && (r_state == S_LOAD);
    w_xfer      = ld_valid && ld_ready;
    w_last_beat = (r_beat == LAST_BEAT);
    w_t_last    = (r_t == LAST_T);
    busy        = !reset && ((r_state == S_CLEAR) || (r_state == S_FEED));
    w_clear_arr = (r_state == S_CLEAR) && !r_keep;
    arr_reset   = reset || w_clear_arr;
  end

`ifdef SYSTOLIC_CTRL_ACCUM_EN
  // Latch the accumulate request with the final load beat
  always_ff @(posedge clock) begin
    if (reset) begin
      r_keep <= 1'b0;
    end else if (w_xfer && w_last_beat) begin
      r_keep <= acc_keep;
    end
  end
`else
  // Without the accumulate option every CLEAR wipes the array
  always_comb begin
    r_keep = 1'b0;
  end
`endif

  // Sequencer: beat counter, feed time counter and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_beat      <= '0;
      r_t         <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_CLEAR;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        S_CLEAR: begin
          r_t     <= '0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (w_t_last) begin
            r_res_data  <= arr_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_t <= r_t + TW'(1);
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Operand storage; the beat number selects A or B row, lane k is column k
  always_ff @(posedge clock) begin
    for (int r = 0; r < DIM; r++) begin
      for (int k = 0; k < DIM; k++) begin
        if (w_xfer && (r_beat == BW'(r))) begin
          r_a[r][k] <= ld_data[LW-1-k*WIDTH -: WIDTH];
        end
        if (w_xfer && (r_beat == BW'(DIM+r))) begin
          r_b[r][k] <= ld_data[LW-1-k*WIDTH -: WIDTH];
        end
      end
    end
  end

  // Skewed wavefronts: element k of row/column i enters at t = i + k
  always_comb begin
    w_left = '0;
    w_top  = '0;
    if (!reset && (r_state == S_FEED)) begin
      for (int i = 0; i < DIM; i++) begin
        for (int k = 0; k < DIM; k++) begin
          if (int'(r_t) == i + k) begin
            w_left[LW-1-i*WIDTH -: WIDTH] = r_a[i][k];
            w_top[LW-1-i*WIDTH -: WIDTH]  = r_b[k][i];
          end
        end
      end
    end
  end

  assign arr_inp_left = w_left;
  assign arr_inp_top  = w_top;
  assign res_data     = r_res_data;
  assign res_valid    = r_res_valid;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table-driven bench for systolic_ctrl with a behavioural
// output-stationary array attached and a scoreboard of expected results.
module tb_systolic_ctrl;
  localparam int WIDTH = 8;
  localparam int DIM   = 3;
  localparam int LW    = DIM*WIDTH;
  localparam int MW    = DIM*DIM*WIDTH;
  localparam int RW    = 2*DIM*DIM*WIDTH;
  localparam int CW    = 2*WIDTH;

  typedef logic [MW-1:0] mat_t;
  typedef logic [RW-1:0] res_t;

  typedef struct packed {
    mat_t       a;
    mat_t       b;
    logic       keep;
    logic       gaps;
    logic [3:0] hold;
    res_t       exp;
  } vec_t;

  logic          clock;
  logic          reset;
  logic [LW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          arr_reset;
  logic [LW-1:0] arr_inp_left;
  logic [LW-1:0] arr_inp_top;
  res_t          arr_result;
  res_t          res_data;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
  logic          acc_keep;
`endif

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  logic cur_keep;
  vec_t vecs[8];
  int   n_vec;

  systolic_ctrl #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clock(clock),
    .reset(reset),
    .ld_data(ld_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    .acc_keep(acc_keep),
`endif
    .arr_reset(arr_reset),
    .arr_inp_left(arr_inp_left),
    .arr_inp_top(arr_inp_top),
    .arr_result(arr_result),
    .res_data(res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural output-stationary array: operands shift right/down, each cell MACs
  logic [WIDTH-1:0] m_l [DIM][DIM];
  logic [WIDTH-1:0] m_t [DIM][DIM];
  logic [WIDTH-1:0] w_lin [DIM][DIM];
  logic [WIDTH-1:0] w_tin [DIM][DIM];
  logic [CW-1:0]    m_acc [DIM][DIM];

  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      w_lin[i][0] = arr_inp_left[LW-1-i*WIDTH -: WIDTH];
      w_tin[0][i] = arr_inp_top[LW-1-i*WIDTH -: WIDTH];
      for (int j = 1; j < DIM; j++) begin
        w_lin[i][j] = m_l[i][j-1];
        w_tin[j][i] = m_t[j-1][i];
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        if (arr_reset) begin
          m_l[i][j]   <= '0;
          m_t[i][j]   <= '0;
          m_acc[i][j] <= '0;
        end else begin
          m_l[i][j]   <= w_lin[i][j];
          m_t[i][j]   <= w_tin[i][j];
          m_acc[i][j] <= m_acc[i][j] + CW'(w_lin[i][j]) * CW'(w_tin[i][j]);
        end
      end
    end
  end

  always_comb begin
    arr_result = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        arr_result[RW-1-(r*DIM+c)*CW -: CW] = m_acc[r][c];
      end
    end
  end

  function automatic logic [WIDTH-1:0] mget(mat_t m, int r, int c);
    return m[MW-1-(r*DIM+c)*WIDTH -: WIDTH];
  endfunction

  function automatic mat_t mat_fill(logic [WIDTH-1:0] v);
    mat_t m;
    for (int n = 0; n < DIM*DIM; n++) m[MW-1-n*WIDTH -: WIDTH] = v;
    return m;
  endfunction

  function automatic mat_t mat_ident();
    mat_t m;
    m = '0;
    for (int n = 0; n < DIM; n++) m[MW-1-(n*DIM+n)*WIDTH -: WIDTH] = 8'd1;
    return m;
  endfunction

  function automatic mat_t mat_seq();
    mat_t m;
    for (int n = 0; n < DIM*DIM; n++) m[MW-1-n*WIDTH -: WIDTH] = WIDTH'(n + 1);
    return m;
  endfunction

  function automatic mat_t mat_rand();
    mat_t m;
    for (int n = 0; n < DIM*DIM; n++) m[MW-1-n*WIDTH -: WIDTH] = WIDTH'($urandom);
    return m;
  endfunction

  function automatic res_t res_fill(logic [CW-1:0] v);
    res_t x;
    for (int n = 0; n < DIM*DIM; n++) x[RW-1-n*CW -: CW] = v;
    return x;
  endfunction

  function automatic res_t res_seq();
    res_t x;
    for (int n = 0; n < DIM*DIM; n++) x[RW-1-n*CW -: CW] = CW'(n + 1);
    return x;
  endfunction

  function automatic res_t matmul(mat_t a, mat_t b);
    res_t          x;
    logic [CW-1:0] s;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        s = '0;
        for (int k = 0; k < DIM; k++) s = s + CW'(mget(a, r, k)) * CW'(mget(b, k, c));
        x[RW-1-(r*DIM+c)*CW -: CW] = s;
      end
    end
    return x;
  endfunction

  function automatic logic [LW-1:0] left_exp(mat_t a, int t);
    logic [LW-1:0] v;
    int            k;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      k = t - i;
      if (k >= 0 && k < DIM) v[LW-1-i*WIDTH -: WIDTH] = mget(a, i, k);
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] top_exp(mat_t b, int t);
    logic [LW-1:0] v;
    int            k;
    v = '0;
    for (int j = 0; j < DIM; j++) begin
      k = t - j;
      if (k >= 0 && k < DIM) v[LW-1-j*WIDTH -: WIDTH] = mget(b, k, j);
    end
    return v;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkl(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkr(string name, res_t act, res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push 2*DIM beats; returns #1 after the edge that transfers the last beat
  task automatic load_mats(mat_t a, mat_t b, logic gaps, logic keep);
    int w;
    int idle;
    cur_keep = keep;
    for (int bt = 0; bt < 2*DIM; bt++) begin
      if (gaps) begin
        idle = $urandom_range(0, 2);
        ld_valid = 1'b0;
        for (int g = 0; g < idle; g++) begin
          @(posedge clock); #1;
        end
      end
      ld_data = (bt < DIM) ? a[MW-1-bt*LW -: LW] : b[MW-1-(bt-DIM)*LW -: LW];
`ifdef SYSTOLIC_CTRL_ACCUM_EN
      acc_keep = keep;
`endif
      ld_valid = 1'b1;
      w = 0;
      while (!ld_ready && w < 50) begin
        @(posedge clock); #1;
        w++;
      end
      if (!ld_ready) begin
        checks++;
        errors++;
        $display("FAIL ld_wait: ld_ready still 0 after %0d cycles, required 1", w);
      end
      @(posedge clock); #1;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
  endtask

  // Follow CLEAR and FEED, then collect the result (optionally stalling the consumer)
  task automatic run_result(mat_t a, mat_t b, int hold);
    int   w;
    res_t d0;
    res_t e;
    chk1("clear_arr_reset", arr_reset, !cur_keep);
    chk1("clear_busy", busy, 1'b1);
    chk1("clear_ld_ready", ld_ready, 1'b0);
    chkl("clear_left", arr_inp_left, '0);
    chkl("clear_top", arr_inp_top, '0);
    for (int t = 0; t <= 3*DIM-2; t++) begin
      @(posedge clock); #1;
      chkl("feed_left", arr_inp_left, left_exp(a, t));
      chkl("feed_top", arr_inp_top, top_exp(b, t));
      chk1("feed_busy", busy, 1'b1);
    end
    @(posedge clock); #1;
    w = 0;
    while (!res_valid && w < 20) begin
      @(posedge clock); #1;
      w++;
    end
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL res_latency: res_valid late by %0d cycles, required 0", w);
    end
    d0 = res_data;
    for (int h = 0; h < hold; h++) begin
      ld_valid = 1'b1;
      ld_data  = LW'($urandom);
      @(posedge clock); #1;
      chk1("hold_valid", res_valid, 1'b1);
      chkr("hold_stable", res_data, d0);
      chk1("hold_ld_ready", ld_ready, 1'b0);
    end
    ld_valid  = 1'b0;
    ld_data   = '0;
    res_ready = 1'b1;
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got result with empty queue, required a pending entry");
    end else begin
      e = sb_q.pop_front();
      chkr("result", res_data, e);
    end
    @(posedge clock); #1;
    chk1("post_valid", res_valid, 1'b0);
    chk1("post_ld_ready", ld_ready, 1'b1);
    chk1("post_busy", busy, 1'b0);
  endtask

  initial begin
    mat_t ra;
    mat_t rb;
    reset     = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = '0;
    res_ready = 1'b1;
    cur_keep  = 1'b0;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    acc_keep  = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk1("rst_arr_reset", arr_reset, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chkr("rst_res_data", res_data, '0);
    chkl("rst_left", arr_inp_left, '0);
    chkl("rst_top", arr_inp_top, '0);
    reset = 1'b0;
    #1;
    chk1("idle_ld_ready", ld_ready, 1'b1);
    chk1("idle_arr_reset", arr_reset, 1'b0);

    ra = mat_rand();
    rb = mat_rand();
    vecs[0] = '{a: mat_ident(),        b: mat_seq(),          keep: 1'b0, gaps: 1'b0, hold: 4'd0, exp: res_seq()};
    vecs[1] = '{a: mat_fill(8'd1),     b: mat_fill(8'd1),     keep: 1'b0, gaps: 1'b0, hold: 4'd0, exp: res_fill(16'd3)};
    // 3*255*255 = 195075 wraps to 64003
    vecs[2] = '{a: mat_fill(8'd255),   b: mat_fill(8'd255),   keep: 1'b0, gaps: 1'b0, hold: 4'd0, exp: res_fill(16'd64003)};
    vecs[3] = '{a: ra,                 b: rb,                 keep: 1'b0, gaps: 1'b1, hold: 4'd5, exp: matmul(ra, rb)};
    n_vec = 4;
`ifdef SYSTOLIC_CTRL_ACCUM_EN
    vecs[4] = '{a: mat_fill(8'd1),     b: mat_fill(8'd1),     keep: 1'b0, gaps: 1'b0, hold: 4'd0, exp: res_fill(16'd3)};
    vecs[5] = '{a: mat_fill(8'd1),     b: mat_fill(8'd1),     keep: 1'b1, gaps: 1'b0, hold: 4'd0, exp: res_fill(16'd6)};
    vecs[6] = '{a: mat_fill(8'd1),     b: mat_fill(8'd1),     keep: 1'b0, gaps: 1'b0, hold: 4'd0, exp: res_fill(16'd3)};
    n_vec = 7;
`endif

    for (int v = 0; v < n_vec; v++) begin
      res_ready = (vecs[v].hold == 4'd0);
      load_mats(vecs[v].a, vecs[v].b, vecs[v].gaps, vecs[v].keep);
      sb_q.push_back(vecs[v].exp);
      run_result(vecs[v].a, vecs[v].b, int'(vecs[v].hold));
    end

    // Reset in the middle of FEED discards the tile and clears the array
    res_ready = 1'b1;
    load_mats(mat_fill(8'd1), mat_fill(8'd1), 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    chkl("t3_left", arr_inp_left, left_exp(mat_fill(8'd1), 3));
    reset = 1'b1;
    #1;
    chk1("midrst_arr_reset", arr_reset, 1'b1);
    chk1("midrst_ld_ready", ld_ready, 1'b0);
    chkl("midrst_left", arr_inp_left, '0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk1("after_rst_ld_ready", ld_ready, 1'b1);
    chk1("after_rst_busy", busy, 1'b0);
    chk1("after_rst_arr_reset", arr_reset, 1'b0);
    chk1("after_rst_res_valid", res_valid, 1'b0);
    chkl("after_rst_left", arr_inp_left, '0);
    chkl("after_rst_top", arr_inp_top, '0);
    chkr("after_rst_array", arr_result, '0);

    ra = mat_rand();
    rb = mat_rand();
    load_mats(ra, rb, 1'b1, 1'b0);
    sb_q.push_back(matmul(ra, rb));
    run_result(ra, rb, 0);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
